// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared CPU definitions used by the load unit: load subtype
//             encodings, the load opcode, the idle ROB tag and the load-unit
//             FSM state enumeration, plus a misalignment helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [6:0] LOAD_OPCODE = 7'b0000011;

  // Load subtypes (funct3 of the load instruction)
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  // Tag shown on the CDB while no result is being broadcast
  localparam logic [5:0] INVALID_ROB = 6'd16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_BCAST = 3'd3,
    ST_DRAIN = 3'd4
  } load_state_t;

  // Halfword loads need addr[0]=0, word loads need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] ld_type,
                                         input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if ((ld_type == LD_LH) || (ld_type == LD_LHU)) mis = lane[0];
    else if (ld_type == LD_LW)                      mis = (lane != 2'b00);
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
//  Module   : load_extract
//  Purpose  : Combinational lane select and sign/zero extension of a
//             little-endian memory word for byte, half and word loads.
//  Ports    : word    in  32  word returned by data memory
//             lane    in  2   low byte-address bits of the load
//             ld_type in  3   load subtype
//             result  out 32  extended load result (0 for unused subtypes)
//  Revision : 1.0 - initial release
// ============================================================================
module load_extract
  import cpu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    // Halfword lane ignores lane[0]: misaligned halves are truncated.
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (ld_type)
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LW:   result = word;
      LD_LBU:  result = {24'd0, byte_sel};
      LD_LHU:  result = {16'd0, half_sel};
      default: result = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_unit
//  Purpose  : Load execution stage. Accepts one dispatched load, issues an
//             aligned word read to data memory, extracts/extends the result
//             and broadcasts it with its ROB tag on the CDB. One load in
//             flight; busy back-pressures the reservation station.
//  Ports    : clock, reset (async, active-high)
//             issue_valid/addr/type/rob in, busy out, flush in
//             mem_req_valid/addr out, mem_req_ready in
//             mem_resp_valid/data in
//             cdb_valid/data/rob out, cdb_grant in
//             cdb_exc out (only with LOAD_MISALIGN_CHECK_EN)
//  Config   : LOAD_MISALIGN_CHECK_EN - misaligned LH/LHU/LW skip memory and
//             broadcast data 0 with cdb_exc=1.
//  Revision : 1.0 - initial release
// ============================================================================
module load_unit
  import cpu_pkg::*;
#(
  parameter int               ROB_W       = 6,
  parameter int               ADDR_W      = 32,
  parameter logic [ROB_W-1:0] INVALID_ROB = ROB_W'(cpu_pkg::INVALID_ROB)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [2:0]        issue_type,
  input  logic [ROB_W-1:0]  issue_rob,
  output logic              busy,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic              cdb_valid,
  output logic [31:0]       cdb_data,
  output logic [ROB_W-1:0]  cdb_rob,
`ifdef LOAD_MISALIGN_CHECK_EN
  output logic              cdb_exc,
`endif
  input  logic              cdb_grant
);

  load_state_t       state, state_next;
  logic              busy_next;
  logic              mem_req_valid_next;
  logic [ADDR_W-1:0] mem_req_addr_next;
  logic              cdb_valid_next;
  logic [31:0]       cdb_data_next;
  logic [ROB_W-1:0]  cdb_rob_next;
  logic [1:0]        lane, lane_next;
  logic [2:0]        ld_type, ld_type_next;
  logic [ROB_W-1:0]  rob, rob_next;
  logic [31:0]       extracted;
  logic              to_idle;
`ifdef LOAD_MISALIGN_CHECK_EN
  logic              cdb_exc_next;
`endif

  load_extract u_extract (
    .word    (mem_resp_data),
    .lane    (lane),
    .ld_type (ld_type),
    .result  (extracted)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      cdb_valid     <= 1'b0;
      cdb_data      <= 32'd0;
      cdb_rob       <= INVALID_ROB;
      lane          <= 2'b00;
      ld_type       <= 3'b000;
      rob           <= '0;
`ifdef LOAD_MISALIGN_CHECK_EN
      cdb_exc       <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      busy          <= busy_next;
      mem_req_valid <= mem_req_valid_next;
      mem_req_addr  <= mem_req_addr_next;
      cdb_valid     <= cdb_valid_next;
      cdb_data      <= cdb_data_next;
      cdb_rob       <= cdb_rob_next;
      lane          <= lane_next;
      ld_type       <= ld_type_next;
      rob           <= rob_next;
`ifdef LOAD_MISALIGN_CHECK_EN
      cdb_exc       <= cdb_exc_next;
`endif
    end
  end

  always_comb begin
    state_next         = state;
    busy_next          = busy;
    mem_req_valid_next = mem_req_valid;
    mem_req_addr_next  = mem_req_addr;
    cdb_valid_next     = cdb_valid;
    cdb_data_next      = cdb_data;
    cdb_rob_next       = cdb_rob;
    lane_next          = lane;
    ld_type_next       = ld_type;
    rob_next           = rob;
    to_idle            = 1'b0;
`ifdef LOAD_MISALIGN_CHECK_EN
    cdb_exc_next       = cdb_exc;
`endif

    case (state)
      ST_IDLE: begin
        // A flush coinciding with a dispatch drops the load.
        if (flush) begin
          to_idle = 1'b1;
        end else if (issue_valid) begin
          lane_next    = issue_addr[1:0];
          ld_type_next = issue_type;
          rob_next     = issue_rob;
          busy_next    = 1'b1;
`ifdef LOAD_MISALIGN_CHECK_EN
          if (is_misaligned(issue_type, issue_addr[1:0])) begin
            state_next     = ST_BCAST;
            cdb_valid_next = 1'b1;
            cdb_data_next  = 32'd0;
            cdb_rob_next   = issue_rob;
            cdb_exc_next   = 1'b1;
          end else
`endif
          begin
            state_next         = ST_REQ;
            mem_req_valid_next = 1'b1;
            mem_req_addr_next  = {issue_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end

      ST_REQ: begin
        if (mem_req_ready) begin
          // Once accepted, memory owes us a response; a flush must drain it.
          mem_req_valid_next = 1'b0;
          state_next         = flush ? ST_DRAIN : ST_WAIT;
        end else if (flush) begin
          to_idle = 1'b1;
        end
      end

      ST_WAIT: begin
        if (flush) begin
          // Response arriving with the flush is consumed right here.
          if (mem_resp_valid) to_idle = 1'b1;
          else                state_next = ST_DRAIN;
        end else if (mem_resp_valid) begin
          cdb_valid_next = 1'b1;
          cdb_data_next  = extracted;
          cdb_rob_next   = rob;
          state_next     = ST_BCAST;
        end
      end

      ST_BCAST: begin
        if (flush || cdb_grant) to_idle = 1'b1;
      end

      ST_DRAIN: begin
        if (mem_resp_valid) to_idle = 1'b1;
      end

      default: to_idle = 1'b1;
    endcase

    if (to_idle) begin
      state_next         = ST_IDLE;
      busy_next          = 1'b0;
      mem_req_valid_next = 1'b0;
      mem_req_addr_next  = '0;
      cdb_valid_next     = 1'b0;
      cdb_data_next      = 32'd0;
      cdb_rob_next       = INVALID_ROB;
`ifdef LOAD_MISALIGN_CHECK_EN
      cdb_exc_next       = 1'b0;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_unit
//  Purpose  : Self-checking bench for load_unit with a cycle-based memory
//             and CDB arbiter model and an expected-result queue.
//  Config   : honours LOAD_MISALIGN_CHECK_EN (cdb_exc port and behaviour)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_unit;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [31:0] issue_addr;
  logic [2:0]  issue_type;
  logic [5:0]  issue_rob;
  logic        busy;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        cdb_valid;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_rob;
  logic        cdb_grant;
`ifdef LOAD_MISALIGN_CHECK_EN
  logic        cdb_exc;
`endif

  load_unit dut (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_addr     (issue_addr),
    .issue_type     (issue_type),
    .issue_rob      (issue_rob),
    .busy           (busy),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .cdb_valid      (cdb_valid),
    .cdb_data       (cdb_data),
    .cdb_rob        (cdb_rob),
`ifdef LOAD_MISALIGN_CHECK_EN
    .cdb_exc        (cdb_exc),
`endif
    .cdb_grant      (cdb_grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  rob;
    logic        exc;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cycle = 0;
  int          issue_cycle = 0;
  int          lat = 0;
  bit          first_seen = 0;
  int          ready_cnt = 0;
  int          resp_delay = 0;
  int          resp_timer = 0;
  int          grant_cnt = 0;
  int          req_cnt = 0;
  bit          ready_drv = 0;
  bit          resp_pending = 0;
  bit          resp_sent = 0;
  bit          hs_seen = 0;
  bit          spam_issue = 0;
  logic [31:0] cur_word = 32'd0;
  logic [31:0] exp_addr = 32'd0;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_extract(input logic [2:0] t,
                                              input logic [31:0] a,
                                              input logic [31:0] w);
    logic [31:0] sb_w, sh_w;
    logic [31:0] r;
    sb_w = w >> {a[1:0], 3'b000};
    sh_w = w >> {a[1], 4'b0000};
    case (t)
      3'b000:  r = $unsigned(32'($signed(sb_w[7:0])));
      3'b001:  r = $unsigned(32'($signed(sh_w[15:0])));
      3'b010:  r = w;
      3'b100:  r = {24'd0, sb_w[7:0]};
      3'b101:  r = {16'd0, sh_w[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // One clock: sample DUT after the edge, then drive memory/arbiter inputs.
  task automatic tick();
    @(posedge clock);
    #1;
    cycle++;
    if (ready_drv) begin
      req_cnt++;
      resp_pending = 1;
      resp_timer   = resp_delay;
      hs_seen      = 1;
    end
    mem_req_ready = 1'b0;
    if (mem_req_valid) begin
      check_value("req_addr", mem_req_addr, exp_addr);
      check_value("req_busy", {31'd0, busy}, 32'd1);
      if (ready_cnt == 0) mem_req_ready = 1'b1;
      else                ready_cnt--;
    end
    ready_drv = mem_req_ready;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;
    if (resp_pending) begin
      if (resp_timer == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = cur_word;
        resp_pending   = 0;
        resp_sent      = 1;
      end else begin
        resp_timer--;
      end
    end
    cdb_grant = 1'b0;
    if (cdb_valid) begin
      if (sb.size() == 0) begin
        check_value("cdb_unexpected", 32'd1, 32'd0);
      end else begin
        if (!first_seen) begin
          first_seen = 1;
          lat = cycle - issue_cycle;
        end
        check_value("cdb_data", cdb_data, sb[0].data);
        check_value("cdb_rob", {26'd0, cdb_rob}, {26'd0, sb[0].rob});
`ifdef LOAD_MISALIGN_CHECK_EN
        check_value("cdb_exc", {31'd0, cdb_exc}, {31'd0, sb[0].exc});
`endif
        check_value("cdb_busy", {31'd0, busy}, 32'd1);
        if (grant_cnt == 0) begin
          cdb_grant = 1'b1;
          void'(sb.pop_front());
          first_seen = 0;
        end else begin
          grant_cnt--;
        end
      end
    end
    issue_valid = spam_issue && busy;
  endtask

  task automatic issue_load(input logic [31:0] addr, input logic [2:0] t,
                            input logic [5:0] r, input logic [31:0] w,
                            input int rdly, input int pdly, input int gdly,
                            input bit expect_result);
    sb_entry_t e;
    issue_valid = 1'b1;
    issue_addr  = addr;
    issue_type  = t;
    issue_rob   = r;
    cur_word    = w;
    ready_cnt   = rdly;
    resp_delay  = pdly;
    grant_cnt   = gdly;
    exp_addr    = {addr[31:2], 2'b00};
    issue_cycle = cycle;
    e.data = ref_extract(t, addr, w);
    e.rob  = r;
    e.exc  = 1'b0;
`ifdef LOAD_MISALIGN_CHECK_EN
    if ((((t == 3'b001) || (t == 3'b101)) && addr[0]) ||
        ((t == 3'b010) && (addr[1:0] != 2'b00))) begin
      e.data = 32'd0;
      e.exc  = 1'b1;
    end
`endif
    if (expect_result) sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy || (sb.size() != 0) || resp_pending) && (n < 60));
    if (n >= 60) check_value({tag, "_timeout"}, 32'd1, 32'd0);
    check_value({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check_value({tag, "_idle_cdbv"}, {31'd0, cdb_valid}, 32'd0);
    check_value({tag, "_idle_rob"}, {26'd0, cdb_rob}, 32'd16);
    check_value({tag, "_idle_reqv"}, {31'd0, mem_req_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_value({tag, "_reqv"}, {31'd0, mem_req_valid}, 32'd0);
    check_value({tag, "_reqa"}, mem_req_addr, 32'd0);
    check_value({tag, "_cdbv"}, {31'd0, cdb_valid}, 32'd0);
    check_value({tag, "_cdbd"}, cdb_data, 32'd0);
    check_value({tag, "_cdbr"}, {26'd0, cdb_rob}, 32'd16);
`ifdef LOAD_MISALIGN_CHECK_EN
    check_value({tag, "_exc"}, {31'd0, cdb_exc}, 32'd0);
`endif
  endtask

  initial begin
    int n;
    int rc;
    reset = 1'b1;
    issue_valid = 1'b0; issue_addr = 32'd0; issue_type = 3'd0; issue_rob = 6'd0;
    flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_data = 32'd0; cdb_grant = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Word load, all handshakes immediate: result 3 cycles after issue.
    issue_load(32'h100, 3'b010, 6'd5, 32'hDEADBEEF, 0, 0, 0, 1);
    wait_done("lw");
    check_value("lat_lw", lat, 32'd3);

    // Extraction patterns
    issue_load(32'h103, 3'b000, 6'd1, 32'h80123456, 0, 0, 0, 1); wait_done("lb");
    issue_load(32'h103, 3'b100, 6'd2, 32'h80123456, 0, 0, 0, 1); wait_done("lbu");
    issue_load(32'h102, 3'b001, 6'd3, 32'h80123456, 0, 0, 0, 1); wait_done("lh");
    issue_load(32'h102, 3'b101, 6'd4, 32'h80123456, 0, 0, 0, 1); wait_done("lhu");
    issue_load(32'h101, 3'b000, 6'd6, 32'h80123456, 1, 1, 1, 1); wait_done("lb1");
    issue_load(32'h100, 3'b001, 6'd8, 32'h1234F678, 0, 0, 0, 1); wait_done("lh0");
    issue_load(32'h100, 3'b011, 6'd9, 32'hFFFFFFFF, 0, 0, 0, 1); wait_done("t011");
    issue_load(32'h104, 3'b111, 6'd10, 32'hFFFFFFFF, 0, 0, 0, 1); wait_done("t111");

    // Misaligned word: truncated by default, exception when checking enabled.
    rc = req_cnt;
    issue_load(32'h102, 3'b010, 6'd11, 32'h80123456, 0, 0, 0, 1);
    wait_done("lw_mis");
`ifdef LOAD_MISALIGN_CHECK_EN
    check_value("lw_mis_noreq", req_cnt, rc);
`else
    check_value("lw_mis_req", req_cnt, rc + 1);
`endif

    // Memory stalls 4 cycles; competing dispatches are ignored meanwhile.
    issue_load(32'h404, 3'b010, 6'd20, 32'h0BADF00D, 4, 0, 0, 1);
    tick();
    issue_addr = 32'h808; issue_rob = 6'd30; spam_issue = 1; issue_valid = 1'b1;
    wait_done("stall");
    spam_issue = 0;

    // CDB grant withheld 3 cycles
    issue_load(32'h10, 3'b100, 6'd33, 32'h000000A5, 0, 0, 3, 1);
    wait_done("grant");

    // Flush in WAIT, response 2 cycles later is drained.
    issue_load(32'h200, 3'b010, 6'd7, 32'h11112222, 0, 2, 0, 0);
    hs_seen = 0; n = 0;
    do begin tick(); n++; end while (!hs_seen && (n < 10));
    check_value("fw_hs", {31'd0, hs_seen}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_value("fw_busy_drain", {31'd0, busy}, 32'd1);
    resp_sent = 0; n = 0;
    do begin tick(); n++; end while (!resp_sent && (n < 10));
    check_value("fw_resp", {31'd0, resp_sent}, 32'd1);
    check_value("fw_busy_resp", {31'd0, busy}, 32'd1);
    tick();
    check_value("fw_busy_done", {31'd0, busy}, 32'd0);
    check_value("fw_cdbv", {31'd0, cdb_valid}, 32'd0);
    issue_load(32'h204, 3'b010, 6'd12, 32'h33334444, 0, 0, 0, 1);
    wait_done("after_flush");

    // Dispatch and flush together in IDLE: load dropped.
    rc = req_cnt;
    issue_load(32'h20, 3'b010, 6'd1, 32'h55555555, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_value("fi_busy", {31'd0, busy}, 32'd0);
    check_value("fi_reqv", {31'd0, mem_req_valid}, 32'd0);
    tick();
    check_value("fi_noreq", req_cnt, rc);

    // Flush while request not yet accepted
    issue_load(32'h30, 3'b010, 6'd2, 32'h66666666, 5, 0, 0, 0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ready_cnt = 0;
    check_reset_outputs("fr");

    // Reset in the middle of BCAST, then a stray response in IDLE.
    issue_load(32'h300, 3'b010, 6'd13, 32'hCAFEF00D, 0, 0, 10, 1);
    n = 0;
    do begin tick(); n++; end while (!cdb_valid && (n < 10));
    check_value("rb_bcast", {31'd0, cdb_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("rb");
    sb.delete(); grant_cnt = 0; first_seen = 0; ready_drv = 0;
    resp_pending = 0; cdb_grant = 1'b0; mem_req_ready = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    cur_word = 32'h77777777; resp_pending = 1; resp_timer = 0;
    tick();
    tick();
    check_value("stray_cdbv", {31'd0, cdb_valid}, 32'd0);
    check_value("stray_busy", {31'd0, busy}, 32'd0);
    issue_load(32'h301, 3'b000, 6'd14, 32'h0000F100, 0, 0, 0, 1);
    wait_done("recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
